adder_accum: RTL

Frame accumulator placed directly downstream of the adder tree. It consumes the tree's registered sum and its `valid_out` strobe, and adds `num` consecutive valid samples into a widened running total. It presents each completed frame total on a one-entry valid/ready output register. It never stalls its producer, because the adder tree has no backpressure. If a new total arrives while the output register is still held, the new total is dropped and the loss is flagged.

---
 rtl/adder_accum.sv | 84 ++++++++
 1 files changed

// File: rtl/adder_accum.sv
// Sums num consecutive valid samples into one frame total held in a one-entry valid/ready slot.
// The slot loads on the edge of the last sample, the input never stalls, and a total that finds the slot held is dropped and flagged.
module adder_accum #(
  parameter  int bits  = 8,
  parameter  int num   = 4,
  localparam int obits = bits + $clog2(num)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [bits-1:0]  i,
  input  logic             clear,
  output logic [obits-1:0] o,
  output logic             valid_out,
  input  logic             ready,
  output logic             overflow
);

  localparam int CW = (num > 1) ? $clog2(num) : 1;

  typedef enum logic {EMPTY, FULL} slot_e;

  slot_e            slot_q, slot_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [obits-1:0] acc_q, acc_d;
  logic [obits-1:0] o_q, o_d;
  logic             overflow_q, overflow_d;
  logic [obits-1:0] sum;
  logic             last;

  assign sum  = acc_q + obits'(i);
  assign last = (cnt_q == CW'(num - 1));

  always_comb begin
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    o_d        = o_q;
    slot_d     = slot_q;
    overflow_d = 1'b0;

    // The handshake is independent of clear; a completion below may override it.
    if (slot_q == FULL && ready) slot_d = EMPTY;

    if (clear) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (valid) begin
      if (last) begin
        cnt_d = '0;
        acc_d = '0;
        if (slot_q == EMPTY || ready) begin
          o_d    = sum;
          slot_d = FULL;
        end else begin
          overflow_d = 1'b1;
        end
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      o_q        <= '0;
      slot_q     <= EMPTY;
      overflow_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      o_q        <= o_d;
      slot_q     <= slot_d;
      overflow_q <= overflow_d;
    end
  end

  assign o         = o_q;
  assign valid_out = (slot_q == FULL);
  assign overflow  = overflow_q;

endmodule
